// File: rtl/uart_image_loader.sv
// uart_image_loader
//   Receives the packed binary image stream from uart_rx (8 pixels per byte,
//   LSB first) and unpacks every byte into 8 single-bit pixel RAM writes.
//   Once NUM_BYTES bytes are stored, img_valid is raised and held until the
//   core acknowledges with img_ack.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   rx_rdy     one-cycle strobe, rx_data valid in that cycle
//   rx_data    received byte
//   pix_we     pixel RAM write enable
//   pix_addr   pixel RAM write address (byte_cnt*8 + bit index)
//   pix_data   pixel value
//   img_valid  full image stored, held until img_ack
//   img_ack    core has consumed the image (only honoured while img_valid=1)
//   overrun    sticky flag: a byte arrived while busy or full and was dropped
//   byte_cnt   bytes stored for the current image, 0..NUM_BYTES
module uart_image_loader #(
    parameter int NUM_BYTES  = 98,
    parameter int PIX_ADDR_W = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_rdy,
    input  logic [7:0]            rx_data,
    output logic                  pix_we,
    output logic [PIX_ADDR_W-1:0] pix_addr,
    output logic                  pix_data,
    output logic                  img_valid,
    input  logic                  img_ack,
    output logic                  overrun,
    output logic [6:0]            byte_cnt
);

    typedef enum logic [1:0] {WAIT, UNPACK, FULL} state_t;

    state_t                  state, state_d;
    logic [7:0]              shift_reg, shift_d;
    logic [2:0]              bit_idx, idx_d;
    logic [2:0]              nxt_idx;
    logic                    pix_we_d, pix_data_d, valid_d, ovr_d;
    logic [PIX_ADDR_W-1:0]   addr_d;
    logic [PIX_ADDR_W-1:0]   base;
    logic [6:0]              cnt_d;

    // Pixel address of bit 0 for the byte being unpacked.
    assign base    = PIX_ADDR_W'({byte_cnt, 3'b000});
    assign nxt_idx = bit_idx + 3'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= WAIT;
            shift_reg <= '0;
            bit_idx   <= '0;
            pix_we    <= 1'b0;
            pix_addr  <= '0;
            pix_data  <= 1'b0;
            img_valid <= 1'b0;
            overrun   <= 1'b0;
            byte_cnt  <= '0;
        end else begin
            state     <= state_d;
            shift_reg <= shift_d;
            bit_idx   <= idx_d;
            pix_we    <= pix_we_d;
            pix_addr  <= addr_d;
            pix_data  <= pix_data_d;
            img_valid <= valid_d;
            overrun   <= ovr_d;
            byte_cnt  <= cnt_d;
        end
    end

    // Outputs are registered, so the write for bit 0 is set up on the capture
    // edge itself; bit_idx always names the pixel currently on the bus.
    always_comb begin
        state_d    = state;
        shift_d    = shift_reg;
        idx_d      = bit_idx;
        pix_we_d   = 1'b0;
        addr_d     = pix_addr;
        pix_data_d = pix_data;
        valid_d    = img_valid;
        ovr_d      = overrun;
        cnt_d      = byte_cnt;

        case (state)
            WAIT: begin
                if (rx_rdy) begin
                    shift_d    = rx_data;
                    idx_d      = 3'd0;
                    pix_we_d   = 1'b1;
                    addr_d     = base;
                    pix_data_d = rx_data[0];
                    state_d    = UNPACK;
                end
            end

            UNPACK: begin
                // No holding buffer: anything arriving now is lost.
                if (rx_rdy) ovr_d = 1'b1;
                if (bit_idx == 3'd7) begin
                    cnt_d = byte_cnt + 7'd1;
                    if (byte_cnt == 7'(NUM_BYTES - 1)) begin
                        valid_d = 1'b1;
                        state_d = FULL;
                    end else begin
                        state_d = WAIT;
                    end
                end else begin
                    idx_d      = nxt_idx;
                    pix_we_d   = 1'b1;
                    addr_d     = base + PIX_ADDR_W'(nxt_idx);
                    pix_data_d = shift_reg[nxt_idx];
                end
            end

            FULL: begin
                if (img_ack) begin
                    valid_d = 1'b0;
                    cnt_d   = '0;
                    ovr_d   = 1'b0;
                    state_d = WAIT;
                    // A byte arriving with the ack starts the next image at 0.
                    if (rx_rdy) begin
                        shift_d    = rx_data;
                        idx_d      = 3'd0;
                        pix_we_d   = 1'b1;
                        addr_d     = '0;
                        pix_data_d = rx_data[0];
                        state_d    = UNPACK;
                    end
                end else if (rx_rdy) begin
                    ovr_d = 1'b1;
                end
            end

            default: state_d = WAIT;
        endcase
    end

endmodule

// File: doc/uart_image_loader.md
Name: uart_image_loader

Overview:
- Sits inside snn, directly downstream of uart_rx, upstream of the SNN core.
- Consumes the 98-byte UART image stream (28x28 = 784 binary pixels, 8 pixels per byte).
- Unpacks each byte into 8 single-bit writes to the pixel RAM.
- Signals the core with a valid/ack handshake once a full image is stored.

Parameters:
- NUM_BYTES, 98, bytes per image.
- PIX_ADDR_W, 10, pixel RAM address width; must satisfy 2^PIX_ADDR_W >= NUM_BYTES*8.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- rx_rdy  input  1  one-cycle pulse from uart_rx; rx_data is valid in that cycle.
- rx_data  input  8  received byte.
- pix_we  output  1  pixel RAM write enable.
- pix_addr  output  PIX_ADDR_W  pixel RAM write address.
- pix_data  output  1  pixel value.
- img_valid  output  1  full image stored; held until acknowledged.
- img_ack  input  1  core has taken the image; sampled only while img_valid=1.
- overrun  output  1  sticky: at least one byte was dropped.
- byte_cnt  output  7  bytes stored for the current image, 0..NUM_BYTES.

Behaviour:
- All outputs are registered. Reset (async, rst=1) values:
  - state=WAIT; pix_we=0, pix_addr=0, pix_data=0.
  - img_valid=0, overrun=0, byte_cnt=0; shift register cleared.
- States: WAIT, UNPACK, FULL.
- WAIT:
  - rx_rdy=1 at an edge: capture rx_data into shift_reg, bit_idx=0, go to UNPACK.
  - rx_rdy=0: stay in WAIT.
- UNPACK: runs exactly 8 cycles.
  - Each cycle: pix_we=1, pix_addr=byte_cnt*8+bit_idx, pix_data=shift_reg[bit_idx]. Pixel order is LSB first.
  - Latency: the first write is visible the cycle after the capture edge; the last write is visible 8 cycles after it.
  - On the edge that retires bit 7: pix_we drops to 0 and byte_cnt increments.
    - New byte_cnt == NUM_BYTES: go to FULL and set img_valid=1 on that same edge.
    - Otherwise: return to WAIT.
  - rx_rdy=1 during UNPACK: byte dropped, overrun set. No holding buffer exists; the UART byte period (>=10 bit times) far exceeds 8 clocks at every supported baud.
- FULL:
  - img_valid stays 1, pix_we=0.
  - rx_rdy=1 without img_ack: byte dropped, overrun set.
  - img_ack=1: img_valid=0, byte_cnt=0, overrun cleared, go to WAIT.
  - img_ack and rx_rdy in the same cycle: ack takes effect, the byte is captured as byte 0 of the next image, state goes directly to UNPACK, overrun stays cleared.
- img_ack outside FULL is ignored.
- Address arithmetic: byte_cnt*8 is formed as {byte_cnt,3'b000} truncated/extended to PIX_ADDR_W. Maximum address is NUM_BYTES*8-1 = 783; no wrap is possible within an image.
- Reset mid-UNPACK or in FULL: pix_we deasserts immediately (async). The partial image is abandoned and the next byte after reset is treated as byte 0. RAM contents are not cleared.
- rx_data is ignored whenever rx_rdy=0.

Test Plan:
- Reset then idle 20 cycles -> pix_we=0, img_valid=0, overrun=0, byte_cnt=0 throughout.
- Single rx_rdy pulse, rx_data=8'hA5:
  - writes at addr 0..7 in 8 consecutive cycles, starting the cycle after capture.
  - pix_data sequence 1,0,1,0,0,1,0,1.
  - byte_cnt=1 afterward; state back to WAIT.
- Send uart_sample_0 (98 bytes) through uart_tx/uart_rx:
  - exactly 784 writes, addresses 0..783 each written once, values match the file bits.
  - img_valid rises on the edge that retires the last write.
  - byte_cnt=98.
- Second rx_rdy 3 cycles after a capture (mid-UNPACK) -> second byte dropped, overrun=1, only 8 writes occur, byte_cnt increments by 1.
- In FULL:
  - rx_rdy alone -> no writes, overrun=1.
  - Then img_ack together with rx_rdy, rx_data=8'h01 -> img_valid=0, overrun=0; writes at addr 0..7 with pix_data 1,0,0,0,0,0,0,0.
- Assert rst during the 4th write of byte 5 (byte_cnt=5) -> pix_we=0 immediately, byte_cnt=0. The next byte writes addr 0..7.
